host_link_adapter: RTL
======================

// Module: host_link_adapter
// PURPOSE
//  Synthesizable host-channel adapter between a host driver and the core's narrow io_host link.
//  Buffers full-width host words in both directions and serialises/deserialises them into HTIF_WIDTH beats.
//  Monitors the tohost word and a cycle watchdog, so simulation and FPGA tops share one termination path.
// PARAMETERS
//  HTIF_WIDTH  16  link beat width in bits
//  WORD_WIDTH  64  host word width; must be a multiple of HTIF_WIDTH; beats = WORD_WIDTH/HTIF_WIDTH >= 1
//  FIFO_DEPTH  4   entries per direction; power of two, >= 2
//  CNT_WIDTH   64  width of the watchdog cycle counter and max_cycles
// PORTS
//  clk            in   1           single clock; all logic on its rising edge
//  reset          in   1           synchronous, active-high
//  tx_valid       in   1           host word offered toward the core
//  tx_ready       out  1           = !tx_full
//  tx_data        in   WORD_WIDTH  host word toward the core
//  rx_valid       out  1           = !rx_empty
//  rx_ready       in   1           host pops one rx word
//  rx_data        out  WORD_WIDTH  rx FIFO head
//  io_host_in_valid   out 1        beat to core valid
//  io_host_in_ready   in  1        core accepts beat
//  io_host_in_bits    out HTIF_WIDTH beat to core
//  io_host_out_valid  in  1        beat from core valid
//  io_host_out_ready  out 1        adapter accepts beat
//  io_host_out_bits   in  HTIF_WIDTH beat from core
//  tohost_valid   in   1           tohost word written this cycle
//  tohost_data    in   32          tohost value
//  max_cycles     in   CNT_WIDTH   watchdog limit; 0 = disabled
//  done           out  1           sticky; tohost[0]==1 seen
//  exit_code      out  31          tohost>>1 captured with done
//  timeout        out  1           sticky watchdog expiry
//  pass           out  1           = done && exit_code==0 && !timeout
// BEHAVIOUR
//  Reset: both FIFOs empty, beat counters 0, shift reg 0; all valid/done/timeout/pass = 0; exit_code = 0.
//  Handshake: a transfer occurs when valid&&ready on the same edge; valid must not depend on ready.
//  TX serialiser: states IDLE/SEND. IDLE->SEND when tx FIFO non-empty and !(done||timeout).
//   SEND drives slice [tx_beat*HTIF_WIDTH +: HTIF_WIDTH] of FIFO head, LSB beat first, no extra register.
//   Each in-handshake increments tx_beat; on last beat: pop FIFO, tx_beat=0, stay SEND if more words
//   and !(done||timeout), else IDLE. Back-to-back words: no idle cycle. A word in SEND always completes.
//  First beat of a word appears one cycle after the word enters an empty FIFO (push -> visible next cycle).
//  RX deserialiser: beats shift into rx_shift LSB-first by rx_beat index; on last beat push word to rx FIFO.
//   io_host_out_ready = !(rx_beat==last && rx_full): stall only the completing beat on full FIFO.
//  FIFOs: push if valid&&!full, pop if ready&&!empty; simultaneous push+pop legal at any non-full/non-empty
//   occupancy; no bypass at full (push refused even if pop same cycle). Pointers wrap modulo FIFO_DEPTH.
//  Watchdog: cycle_cnt clears on reset, +1 per cycle, saturates at all-ones. timeout sets on the edge where
//   max_cycles!=0 and cycle_cnt+1 == max_cycles (high after exactly max_cycles cycles); sticky until reset.
//  tohost: when tohost_valid && tohost_data[0] && !done: done<=1, exit_code<=tohost_data[31:1]. Later writes
//   ignored. tohost==0 or even values ignored. done and timeout may set on the same edge; pass then 0.
//  Reset mid-transfer: partial words in serialiser/deserialiser are discarded; no beat emitted in reset cycle.
// STRUCTURE
//  Package host_link_pkg: BEATS localparam function, clog2 helpers, tx state enum {IDLE,SEND}.
//  Sub-module host_link_fifo (WIDTH, DEPTH) instantiated twice (tx, rx); rest is flat in this module.
// TESTING
//  1 HTIF=16,WORD=64: push 0x1122_3344_5566_7788, in_ready=1 -> beats 7788,5566,3344,1122 on 4 cycles.
//  2 Core sends beats 0001,0002,0003,0004 -> rx_data=0x0004_0003_0002_0001, rx_valid next cycle.
//  3 rx_ready=0, send 5 words (DEPTH 4) -> 4 queued, 5th word's last beat stalls out_ready=0; pop one -> accepted.
//  4 tohost_data=3 then 5 -> done=1, exit_code=1, pass=0; second write ignored; tohost=1 alone -> pass=1.
//  5 max_cycles=10 -> timeout rises exactly 10 cycles after reset release; max_cycles=0 -> never.
//  6 Reset asserted mid-word (after 2 beats) -> io_host_in_valid=0, FIFOs empty, word not resent.

Source files
------------

// File: rtl/host_link_pkg.sv
// host_link_pkg
//   Shared definitions for the host link adapter:
//     - tx_state_t : serialiser state encoding (IDLE / SEND)
//     - clog2      : ceiling log2 for elaboration-time sizing
//     - beats      : number of link beats per host word
//     - idx_width  : width of an index into n items (at least 1 bit)
package host_link_pkg;

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    SEND = 1'b1
  } tx_state_t;

  function automatic int clog2(input int value);
    int r;
    r = 0;
    for (int v = value - 1; v > 0; v = v >> 1) begin
      r = r + 1;
    end
    return r;
  endfunction

  function automatic int beats(input int word_w, input int htif_w);
    return word_w / htif_w;
  endfunction

  // A counter over a single item still needs one bit to exist.
  function automatic int idx_width(input int n);
    return (n > 1) ? clog2(n) : 1;
  endfunction

endpackage

// File: rtl/host_link_fifo.sv
// host_link_fifo
//   Synchronous FIFO used for both directions of the host link adapter.
//   Push when push_valid and not full; pop when pop_ready and not empty.
//   Simultaneous push and pop are allowed whenever each is individually
//   legal. A full FIFO refuses a push even if a pop happens on the same edge.
//   Ports:
//     clk, reset  : clock, synchronous active-high reset (empties the FIFO)
//     push_valid  : write request, push_data is the word written
//     pop_ready   : read request, pop_data is the current head
//     count       : current occupancy (0..DEPTH); full/empty derive from it
module host_link_fifo
  import host_link_pkg::*;
#(
  parameter int WIDTH = 64,
  parameter int DEPTH = 4
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        push_valid,
  input  logic [WIDTH-1:0]            push_data,
  input  logic                        pop_ready,
  output logic [WIDTH-1:0]            pop_data,
  output logic [idx_width(DEPTH):0]   count
);

  localparam int AW = idx_width(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             full;
  logic             empty;
  logic             do_push;
  logic             do_pop;

  assign full     = (count == (AW+1)'(DEPTH));
  assign empty    = (count == '0);
  assign do_push  = push_valid && !full;
  assign do_pop   = pop_ready && !empty;
  assign pop_data = mem[rd_ptr];

  // DEPTH is a power of two, so the pointers wrap naturally.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + (AW+1)'(1);
        2'b01:   count <= count - (AW+1)'(1);
        default: count <= count;
      endcase
    end
  end

  // Storage needs no reset: empty/full tracking guards every read.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

endmodule

// File: rtl/host_link_adapter.sv
// host_link_adapter
//   Host-channel adapter between a host driver and the core's narrow io_host
//   link. Host words are queued in a tx FIFO and serialised LSB beat first
//   onto io_host_in; beats from io_host_out are reassembled and queued in an
//   rx FIFO for the host. A tohost monitor and a cycle watchdog give
//   simulation and FPGA tops a common termination signal.
//   Ports:
//     clk, reset                 : clock, synchronous active-high reset
//     tx_valid/tx_ready/tx_data  : host words toward the core
//     rx_valid/rx_ready/rx_data  : host words from the core (FIFO head)
//     io_host_in_*               : beats toward the core
//     io_host_out_*              : beats from the core
//     tohost_valid/tohost_data   : tohost write monitor input
//     max_cycles                 : watchdog limit, 0 disables it
//     done/exit_code             : sticky completion and captured exit code
//     timeout                    : sticky watchdog expiry
//     pass                       : done with exit code 0 and no timeout
//     tx_state                   : serialiser state, for observation
//   Handshake rule for every valid/ready pair: a transfer happens on an edge
//   where valid and ready are both high; valid never depends on ready.
module host_link_adapter
  import host_link_pkg::*;
#(
  parameter int HTIF_WIDTH = 16,
  parameter int WORD_WIDTH = 64,
  parameter int FIFO_DEPTH = 4,
  parameter int CNT_WIDTH  = 64
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  tx_valid,
  output logic                  tx_ready,
  input  logic [WORD_WIDTH-1:0] tx_data,
  output logic                  rx_valid,
  input  logic                  rx_ready,
  output logic [WORD_WIDTH-1:0] rx_data,
  output logic                  io_host_in_valid,
  input  logic                  io_host_in_ready,
  output logic [HTIF_WIDTH-1:0] io_host_in_bits,
  input  logic                  io_host_out_valid,
  output logic                  io_host_out_ready,
  input  logic [HTIF_WIDTH-1:0] io_host_out_bits,
  input  logic                  tohost_valid,
  input  logic [31:0]           tohost_data,
  input  logic [CNT_WIDTH-1:0]  max_cycles,
  output logic                  done,
  output logic [30:0]           exit_code,
  output logic                  timeout,
  output logic                  pass,
  output tx_state_t             tx_state
);

  localparam int BEATS = beats(WORD_WIDTH, HTIF_WIDTH);
  localparam int BW    = idx_width(BEATS);
  localparam int AW    = idx_width(FIFO_DEPTH);
  localparam logic [BW-1:0] LAST_BEAT = BW'(BEATS - 1);
  localparam logic [AW:0]   DEPTH_CNT = (AW+1)'(FIFO_DEPTH);

  // ---------------------------------------------------------------- tx path
  logic [WORD_WIDTH-1:0] tx_head;
  logic [AW:0]           tx_count;
  logic                  tx_push;
  logic                  tx_pop;
  logic                  tx_more;
  logic                  tx_last;
  logic                  in_fire;
  logic                  halted;
  logic [BW-1:0]         tx_beat;
  tx_state_t             state;
  tx_state_t             state_next;

  assign tx_ready = (tx_count != DEPTH_CNT);
  assign tx_push  = tx_valid && tx_ready;
  assign halted   = done || timeout;
  assign tx_last  = (tx_beat == LAST_BEAT);
  assign in_fire  = io_host_in_valid && io_host_in_ready;
  assign tx_pop   = in_fire && tx_last;
  // Another word is ready right after this pop: either one is already queued
  // behind the head, or one is being pushed on the same edge.
  assign tx_more  = (tx_count > (AW+1)'(1)) || tx_push;
  assign tx_state = state;

  host_link_fifo #(
    .WIDTH (WORD_WIDTH),
    .DEPTH (FIFO_DEPTH)
  ) u_tx_fifo (
    .clk        (clk),
    .reset      (reset),
    .push_valid (tx_valid),
    .push_data  (tx_data),
    .pop_ready  (tx_pop),
    .pop_data   (tx_head),
    .count      (tx_count)
  );

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  // A word already in SEND always completes; halting only prevents the
  // serialiser from starting another one.
  always_comb begin
    state_next = state;
    case (state)
      IDLE: if ((tx_count != '0) && !halted) state_next = SEND;
      SEND: if (tx_pop && !(tx_more && !halted)) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Beats come straight from the FIFO head; no output register. The reset
  // term keeps a stale SEND state from emitting a beat during reset.
  always_comb begin
    io_host_in_valid = (state == SEND) && !reset;
    io_host_in_bits  = tx_head[int'(tx_beat)*HTIF_WIDTH +: HTIF_WIDTH];
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      tx_beat <= '0;
    end else if (in_fire) begin
      tx_beat <= tx_last ? '0 : tx_beat + BW'(1);
    end
  end

  // ---------------------------------------------------------------- rx path
  logic [WORD_WIDTH-1:0] rx_shift;
  logic [WORD_WIDTH-1:0] rx_word;
  logic [AW:0]           rx_count;
  logic [BW-1:0]         rx_beat;
  logic                  rx_last;
  logic                  rx_full;
  logic                  out_fire;
  logic                  rx_push;
  logic                  rx_pop;

  assign rx_last  = (rx_beat == LAST_BEAT);
  assign rx_full  = (rx_count == DEPTH_CNT);
  assign rx_valid = (rx_count != '0);
  assign rx_pop   = rx_ready && rx_valid;
  // Only the beat that completes a word needs FIFO space, so only it stalls.
  assign io_host_out_ready = !(rx_last && rx_full);
  assign out_fire = io_host_out_valid && io_host_out_ready;
  assign rx_push  = out_fire && rx_last;

  // The word pushed on the last beat includes that beat, merged here.
  always_comb begin
    rx_word = rx_shift;
    rx_word[int'(rx_beat)*HTIF_WIDTH +: HTIF_WIDTH] = io_host_out_bits;
  end

  host_link_fifo #(
    .WIDTH (WORD_WIDTH),
    .DEPTH (FIFO_DEPTH)
  ) u_rx_fifo (
    .clk        (clk),
    .reset      (reset),
    .push_valid (rx_push),
    .push_data  (rx_word),
    .pop_ready  (rx_pop),
    .pop_data   (rx_data),
    .count      (rx_count)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      rx_beat  <= '0;
      rx_shift <= '0;
    end else if (out_fire) begin
      rx_beat  <= rx_last ? '0 : rx_beat + BW'(1);
      rx_shift <= rx_last ? '0 : rx_word;
    end
  end

  // ----------------------------------------------------- watchdog / tohost
  logic [CNT_WIDTH-1:0] cycle_cnt;

  // Saturates so a disabled watchdog never wraps back into a match.
  always_ff @(posedge clk) begin
    if (reset) begin
      cycle_cnt <= '0;
    end else if (cycle_cnt != '1) begin
      cycle_cnt <= cycle_cnt + CNT_WIDTH'(1);
    end
  end

  // Comparing cycle_cnt+1 makes timeout visible after exactly max_cycles
  // edges following reset release.
  always_ff @(posedge clk) begin
    if (reset) begin
      timeout <= 1'b0;
    end else if ((max_cycles != '0) && (cycle_cnt + CNT_WIDTH'(1) == max_cycles)) begin
      timeout <= 1'b1;
    end
  end

  // First odd tohost write wins; everything after it is ignored.
  always_ff @(posedge clk) begin
    if (reset) begin
      done      <= 1'b0;
      exit_code <= '0;
    end else if (tohost_valid && tohost_data[0] && !done) begin
      done      <= 1'b1;
      exit_code <= tohost_data[31:1];
    end
  end

  assign pass = done && (exit_code == '0) && !timeout;

endmodule
